// File: rtl/ddr_scanout_prefetch_pkg.sv
// Shared types and constants for the framebuffer scanout prefetcher.
package ddr_scanout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // 640x480 at 16 bpp, one word per pixel
  localparam int DEFAULT_FRAME_WORDS = 307200;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ddr_scanout_prefetch_if.sv
// Read-request / read-return bus between the prefetcher (master) and the Ddr controller (slave).
interface ddr_scanout_prefetch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 24
);
  logic                  rdReq;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic                  rdAck;
  logic                  rdValid;
  logic [DATA_WIDTH-1:0] readData;

  modport master (output rdReq, rdAddr, input rdAck, rdValid, readData);
  modport slave  (input rdReq, rdAddr, output rdAck, rdValid, readData);
endinterface

// File: rtl/ddr_scanout_prefetch_pixel_fifo.sv
// Show-ahead pixel FIFO: head is visible combinationally, pointers move on the next edge.
module pixel_fifo
  import ddr_scanout_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 32,
  localparam int PW         = ptr_w(DEPTH)
) (
  input  logic                  clk133_p,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [PW:0]           o_level
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_level;
  logic                  w_do_pop;
  logic                  w_do_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (PW+1)'(DEPTH));
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop on empty is ignored; a push on full only lands if the head leaves in the same cycle
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk133_p) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_do_pop};
    end
  end

endmodule

// File: rtl/ddr_scanout_prefetch.sv
// Walks the framebuffer issuing credit-throttled burst reads and buffers the returned pixels.
module ddr_scanout_prefetch
  import ddr_scanout_pkg::*;
#(
  parameter  int DATA_WIDTH  = 16,
  parameter  int ADDR_WIDTH  = 24,
  parameter  int BURST_LEN   = 2,
  parameter  int DEPTH       = 32,
  parameter  int FRAME_WORDS = DEFAULT_FRAME_WORDS,
  localparam int LW          = ptr_w(DEPTH) + 1,
  localparam int RCW         = $clog2(FRAME_WORDS + 1)
) (
  input  logic                   clk133_p,
  input  logic                   rst,
  input  logic                   frameStart,
  input  logic [ADDR_WIDTH-1:0]  baseAddr,
  ddr_scanout_prefetch_if.master ddr,
  input  logic                   pixPop,
  output logic [DATA_WIDTH-1:0]  pixData,
  output logic                   pixValid,
  output logic [LW-1:0]          level,
  output logic                   frameDone,
  output logic                   underflow,
  output logic                   overflow
);

  state_t                r_state, w_state_next;
  logic                  r_rd_req, w_rd_req_next;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_next;
  logic [RCW-1:0]        r_req_count, w_req_count_next;
  logic [LW-1:0]         r_outstanding, w_outstanding_next;
  logic                  r_frame_done, w_frame_done_next;
  logic                  r_underflow;
  logic                  r_overflow;

  logic                  w_accept;
  logic                  w_beat;
  logic                  w_push;
  logic                  w_clr;
  logic                  w_empty;
  logic                  w_full;
  int                    w_used;

  assign w_accept = r_rd_req && ddr.rdAck;
  // Beats with nothing outstanding are stray and never counted or stored
  assign w_beat   = ddr.rdValid && (r_outstanding != '0);
  assign w_push   = w_beat && (r_state != ST_FLUSH);
  assign w_clr    = (r_state == ST_FLUSH) && (r_outstanding == '0);

  always_comb begin
    w_state_next       = r_state;
    w_rd_addr_next     = r_rd_addr;
    w_req_count_next   = r_req_count;
    w_frame_done_next  = r_frame_done;
    w_outstanding_next = r_outstanding
                       + (w_accept ? LW'(BURST_LEN) : LW'(0))
                       - (w_beat ? LW'(1) : LW'(0));

    if (w_accept) begin
      w_rd_addr_next   = r_rd_addr + ADDR_WIDTH'(BURST_LEN);
      w_req_count_next = r_req_count + RCW'(BURST_LEN);
    end

    case (r_state)
      ST_IDLE:  ;
      ST_FLUSH: if (r_outstanding == '0) w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (w_req_count_next == RCW'(FRAME_WORDS) && w_outstanding_next == '0) begin
          w_state_next      = ST_DONE;
          w_frame_done_next = 1'b1;
        end
      end
      ST_DONE:  ;
      default:  w_state_next = ST_IDLE;
    endcase

    if (frameStart) begin
      w_state_next      = ST_FLUSH;
      w_rd_addr_next    = baseAddr;
      w_req_count_next  = '0;
      w_frame_done_next = 1'b0;
    end

    // Credit check counts beats in flight plus any burst accepted this cycle; pops are ignored
    w_used = (w_clr ? 0 : int'(level)) + int'(r_outstanding) + (w_accept ? BURST_LEN : 0);

    w_rd_req_next = 1'b0;
    if (r_rd_req && !w_accept) begin
      w_rd_req_next = 1'b1;
    end else if (w_state_next == ST_FETCH && (w_used + BURST_LEN <= DEPTH) &&
                 int'(w_req_count_next) < FRAME_WORDS) begin
      w_rd_req_next = 1'b1;
    end
    if (frameStart) w_rd_req_next = 1'b0;
  end

  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_rd_req      <= 1'b0;
      r_rd_addr     <= '0;
      r_req_count   <= '0;
      r_outstanding <= '0;
      r_frame_done  <= 1'b0;
      r_underflow   <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rd_req      <= w_rd_req_next;
      r_rd_addr     <= w_rd_addr_next;
      r_req_count   <= w_req_count_next;
      r_outstanding <= w_outstanding_next;
      r_frame_done  <= w_frame_done_next;
      r_underflow   <= r_underflow | (pixPop & w_empty);
      r_overflow    <= r_overflow | (w_push & w_full & ~pixPop);
    end
  end

  pixel_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk133_p (clk133_p),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_push   (w_push),
    .i_data   (ddr.readData),
    .i_pop    (pixPop),
    .o_data   (pixData),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_level  (level)
  );

  assign ddr.rdReq  = r_rd_req;
  assign ddr.rdAddr = r_rd_addr;
  assign pixValid   = !w_empty;
  assign frameDone  = r_frame_done;
  assign underflow  = r_underflow;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ddr_scanout_prefetch.sv
// Directed bench: instance A (full-size frame) for credits/FIFO/flush, instance B (8-word frame) for completion.
module tb_ddr_scanout_prefetch;

  localparam int AW = 24;
  localparam int DW = 16;

  logic clk133_p = 1'b0;
  logic rst      = 1'b0;
  always #5 clk133_p = ~clk133_p;

  int n_total = 0;
  int n_bad   = 0;

  logic          fs_a = 1'b0, pop_a = 1'b0;
  logic [AW-1:0] base_a = '0;
  logic [DW-1:0] pix_a;
  logic          pv_a, done_a, uf_a, of_a;
  logic [5:0]    lvl_a;

  logic          fs_b = 1'b0, pop_b = 1'b0;
  logic [AW-1:0] base_b = '0;
  logic [DW-1:0] pix_b;
  logic          pv_b, done_b, uf_b, of_b;
  logic [5:0]    lvl_b;

  logic [AW-1:0] addrs_b [$];

  ddr_scanout_prefetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
  ddr_scanout_prefetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();

  ddr_scanout_prefetch u_dut_a (
    .clk133_p (clk133_p), .rst (rst), .frameStart (fs_a), .baseAddr (base_a),
    .ddr (if_a), .pixPop (pop_a), .pixData (pix_a), .pixValid (pv_a), .level (lvl_a),
    .frameDone (done_a), .underflow (uf_a), .overflow (of_a)
  );

  ddr_scanout_prefetch #(.FRAME_WORDS(8)) u_dut_b (
    .clk133_p (clk133_p), .rst (rst), .frameStart (fs_b), .baseAddr (base_b),
    .ddr (if_b), .pixPop (pop_b), .pixData (pix_b), .pixValid (pv_b), .level (lvl_b),
    .frameDone (done_b), .underflow (uf_b), .overflow (of_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk133_p);
  endtask

  // Ddr model for instance B: fixed 5-cycle latency, beats serialised one per cycle
  initial begin : ddr_model_b
    int cyc;
    int nreq;
    int due_q [$];
    logic [DW-1:0] dat_q [$];
    cyc  = 0;
    nreq = 0;
    if_b.rdValid  = 1'b0;
    if_b.readData = '0;
    forever begin
      @(negedge clk133_p);
      cyc++;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        if_b.rdValid  = 1'b1;
        if_b.readData = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end else begin
        if_b.rdValid = 1'b0;
      end
      if (if_b.rdReq && if_b.rdAck) begin
        addrs_b.push_back(if_b.rdAddr);
        due_q.push_back(cyc + 5);
        due_q.push_back(cyc + 6);
        dat_q.push_back(16'hB000 + 16'(2 * nreq));
        dat_q.push_back(16'hB001 + 16'(2 * nreq));
        nreq++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int            acc;
    int            stable;
    int            found;
    logic [AW-1:0] first_addr;
    logic [5:0]    prev_lvl;

    if_a.rdAck = 1'b0; if_a.rdValid = 1'b0; if_a.readData = '0;
    if_b.rdAck = 1'b1;

    repeat (3) step();
    chk("rst_rdReq",    32'(if_a.rdReq),  32'd0);
    chk("rst_rdAddr",   32'(if_a.rdAddr), 32'd0);
    chk("rst_pixValid", 32'(pv_a),        32'd0);
    chk("rst_level",    32'(lvl_a),       32'd0);
    chk("rst_done",     32'(done_a),      32'd0);
    chk("rst_uflow",    32'(uf_a),        32'd0);
    chk("rst_oflow",    32'(of_a),        32'd0);
    rst = 1'b1;

    // Credits: no data returns, so only DEPTH/BURST_LEN requests may go out
    step(); fs_a = 1'b1; base_a = 24'h000100; if_a.rdAck = 1'b1;
    step(); fs_a = 1'b0;
    acc = 0; first_addr = '0;
    repeat (40) begin
      step();
      if (if_a.rdReq && if_a.rdAck) begin
        if (acc == 0) first_addr = if_a.rdAddr;
        acc++;
      end
    end
    chk("credit_first_addr", 32'(first_addr),  32'h100);
    chk("credit_req_count",  32'(acc),         32'd16);
    chk("credit_rdReq_low",  32'(if_a.rdReq),  32'd0);
    chk("credit_last_addr",  32'(if_a.rdAddr), 32'h120);

    // Two beats in, then one pop
    if_a.rdValid = 1'b1; if_a.readData = 16'h5555;
    step(); if_a.readData = 16'hAAAA;
    step(); if_a.rdValid = 1'b0;
    chk("fifo_level2",   32'(lvl_a), 32'd2);
    chk("fifo_head",     32'(pix_a), 32'h5555);
    chk("fifo_valid",    32'(pv_a),  32'd1);
    pop_a = 1'b1;
    step(); pop_a = 1'b0;
    chk("fifo_pop_head", 32'(pix_a), 32'hAAAA);
    chk("fifo_level1",   32'(lvl_a), 32'd1);
    chk("credit_full",   32'(if_a.rdReq), 32'd0);

    // Stall: free one credit with rdAck low, request must hold steady
    if_a.rdAck = 1'b0; pop_a = 1'b1;
    step(); pop_a = 1'b0;
    step();
    chk("stall_rdReq_up", 32'(if_a.rdReq),  32'd1);
    chk("stall_addr",     32'(if_a.rdAddr), 32'h120);
    stable = 1;
    repeat (10) begin
      step();
      if (if_a.rdReq !== 1'b1 || if_a.rdAddr !== 24'h000120) stable = 0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    if_a.rdAck = 1'b1;
    step(); if_a.rdAck = 1'b0;
    chk("stall_one_req_addr", 32'(if_a.rdAddr), 32'h122);
    chk("stall_rdReq_down",   32'(if_a.rdReq),  32'd0);

    // Restart with beats still outstanding
    for (int k = 0; k < 28; k++) begin
      if_a.rdValid = 1'b1; if_a.readData = 16'(k);
      step();
    end
    if_a.rdValid = 1'b0;
    chk("flush_pre_level", 32'(lvl_a), 32'd28);
    fs_a = 1'b1; base_a = 24'h000800; if_a.rdAck = 1'b1;
    step(); fs_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if_a.rdValid = 1'b1; if_a.readData = 16'hDEAD;
      step();
    end
    if_a.rdValid = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      if (if_a.rdReq) found = 1;
      else step();
    end
    if_a.rdAck = 1'b0;
    chk("flush_req_seen", 32'(found),       32'd1);
    chk("flush_new_base", 32'(if_a.rdAddr), 32'h800);
    chk("flush_level0",   32'(lvl_a),       32'd0);
    chk("flush_oflow",    32'(of_a),        32'd0);

    // Pop while empty
    chk("uflow_before", 32'(uf_a), 32'd0);
    pop_a = 1'b1;
    step(); pop_a = 1'b0;
    chk("uflow_set",   32'(uf_a),  32'd1);
    chk("uflow_lvl",   32'(lvl_a), 32'd0);
    repeat (3) step();
    chk("uflow_stick", 32'(uf_a),  32'd1);

    // Short frame on instance B
    fs_b = 1'b1; base_b = 24'h001000;
    step(); fs_b = 1'b0;
    found = 0; prev_lvl = '0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      step(); #1;
      if (done_b) found = 1;
      else prev_lvl = lvl_b;
    end
    chk("frame_done_seen",  32'(found),          32'd1);
    chk("frame_level8",     32'(lvl_b),          32'd8);
    chk("frame_prev_lvl",   32'(prev_lvl),       32'd7);
    chk("frame_head",       32'(pix_b),          32'hB000);
    chk("frame_req_count",  32'(addrs_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("frame_addr%0d", i),
          32'((i < addrs_b.size()) ? addrs_b[i] : 24'hFFFFFF), 32'(24'h001000 + 24'(2 * i)));
    end
    repeat (10) step();
    chk("frame_no_more_req", 32'(addrs_b.size()), 32'd4);
    chk("frame_rdReq_low",   32'(if_b.rdReq),     32'd0);
    chk("frame_done_hold",   32'(done_b),         32'd1);

    // Asynchronous reset mid-cycle, no clock edge in between
    step();
    chk("areset_pre_req",  32'(if_a.rdReq), 32'd1);
    chk("areset_pre_done", 32'(done_b),     32'd1);
    #2; rst = 1'b0; #1;
    chk("areset_rdReq",  32'(if_a.rdReq),  32'd0);
    chk("areset_rdAddr", 32'(if_a.rdAddr), 32'd0);
    chk("areset_uflow",  32'(uf_a),        32'd0);
    chk("areset_done",   32'(done_b),      32'd0);
    chk("areset_lvl_b",  32'(lvl_b),       32'd0);
    chk("areset_pv_b",   32'(pv_b),        32'd0);
    step(); rst = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
